fetch_queue_unit: RTL

Parametrised successor of the pipeline fetch stage. Holds the PC and issues it to instruction memory, which reads combinationally. Each fetched {pc, instr} pair is pushed into a DEPTH-entry prefetch queue, and decode drains it over a valid/ready handshake. A branch redirect sets the PC to the target and flushes every queued entry. This decouples fetch from decode stalls.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_queue_unit_if.sv | 41 ++++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_queue_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_pkg                                                       |
// | Purpose  : Shared types, default widths and the PC alignment helper for    |
// |            the fetch queue unit.                                           |
// | Contents : PC_W_DEF, INSTR_W_DEF, INSTR_BYTES_DEF, fetch_entry_t,          |
// |            align_pc()                                                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package fetch_pkg;

  localparam int PC_W_DEF        = 64;
  localparam int INSTR_W_DEF     = 32;
  localparam int INSTR_BYTES_DEF = 4;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

  // Clears the low 'lsbs' bits so redirect targets land on an instruction boundary.
  function automatic logic [PC_W_DEF-1:0] align_pc(input logic [PC_W_DEF-1:0] pc,
                                                   input int unsigned         lsbs);
    return pc & ~((PC_W_DEF'(1) << lsbs) - PC_W_DEF'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_queue_unit_if                                             |
// | Purpose  : Bundles the redirect, instruction-memory and decode handshake   |
// |            signals of the fetch queue unit.                                |
// | Signals  : PCSrc_F, PCBranch_F      redirect request / target              |
// |            imem_addr_F, imem_data_F instruction memory address / data      |
// |            out_valid_F, out_ready_F decode handshake                       |
// |            out_pc_F, out_instr_F    queue head                             |
// |            q_count_F                occupied entries                       |
// | Modports : master = fetch unit side, slave = environment side              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface fetch_queue_unit_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               PCSrc_F;
  logic [PC_W-1:0]    PCBranch_F;
  logic [PC_W-1:0]    imem_addr_F;
  logic [INSTR_W-1:0] imem_data_F;
  logic               out_valid_F;
  logic               out_ready_F;
  logic [PC_W-1:0]    out_pc_F;
  logic [INSTR_W-1:0] out_instr_F;
  logic [CNT_W-1:0]   q_count_F;

  modport master (
    input  PCSrc_F, PCBranch_F, imem_data_F, out_ready_F,
    output imem_addr_F, out_valid_F, out_pc_F, out_instr_F, q_count_F
  );

  modport slave (
    output PCSrc_F, PCBranch_F, imem_data_F, out_ready_F,
    input  imem_addr_F, out_valid_F, out_pc_F, out_instr_F, q_count_F
  );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_fifo                                                      |
// | Purpose  : Synchronous DEPTH-entry FIFO holding fetched {pc, instr} pairs. |
// |            Flush has priority over push/pop; reset over everything.        |
// | Ports    : clk, reset (active low, synchronous)                            |
// |            i_push, i_pop, i_flush, i_data  -> control / write data         |
// |            o_head, o_count, o_valid        -> head entry and occupancy     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type T_ENTRY = fetch_entry_t
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       i_push,
  input  wire logic                       i_pop,
  input  wire logic                       i_flush,
  input  wire T_ENTRY                     i_data,
  output T_ENTRY                          o_head,
  output logic [$clog2(DEPTH+1)-1:0]      o_count,
  output logic                            o_valid
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  T_ENTRY             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  // Pointers are exactly log2(DEPTH) bits, so they wrap without extra logic.
  always_ff @(posedge clk) begin
    if (!reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // When full with a simultaneous pop, tail == head: the old head is consumed
  // by decode this cycle, so overwriting that slot is safe.
  always_ff @(posedge clk) begin
    if (reset && !i_flush && i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Head is forced to zero when empty so stale storage never shows on the bus.
  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_queue_unit                                                |
// | Purpose  : Fetch stage with a prefetch queue. Holds the PC, reads the      |
// |            combinational instruction memory and pushes {pc, instr} into a  |
// |            DEPTH-entry queue drained by decode. A redirect loads the       |
// |            aligned target and flushes the queue.                           |
// | Ports    : clk, reset (active low, synchronous)                            |
// |            bus (fetch_queue_unit_if.master): redirect, imem, decode        |
// |            perf_flush_cnt_F, perf_stall_cnt_F (only with FETCH_PERF_CNT_EN)|
// | Options  : FETCH_PERF_CNT_EN - adds saturating flush/stall counters        |
// | Notes    : PC_W must not exceed PC_W_DEF; interface parameters must match. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W         = PC_W_DEF,
  parameter int              INSTR_W      = INSTR_W_DEF,
  parameter int              DEPTH        = 4,
  parameter int              INSTR_BYTES  = INSTR_BYTES_DEF,
  parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(0)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  fetch_queue_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_flush_cnt_F,
  output logic [31:0]        perf_stall_cnt_F
`endif
);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ALIGN_W = $clog2(INSTR_BYTES);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_target;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_valid;
  logic [CNT_W-1:0] w_count;
  entry_t           w_wr_entry;
  entry_t           w_head;

  assign w_full   = (w_count == CNT_W'(DEPTH));
  assign w_pop    = w_valid && bus.out_ready_F;
  // A full queue still accepts a push when decode frees the head this edge.
  assign w_push   = !bus.PCSrc_F && (!w_full || w_pop);
  assign w_target = PC_W'(align_pc(PC_W_DEF'(bus.PCBranch_F), ALIGN_W));

  assign w_wr_entry.pc    = r_pc;
  assign w_wr_entry.instr = bus.imem_data_F;

  // PC wraps modulo 2^PC_W by plain truncation of the add.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= RESET_VECTOR;
    end else if (bus.PCSrc_F) begin
      r_pc <= w_target;
    end else if (w_push) begin
      r_pc <= r_pc + PC_W'(INSTR_BYTES);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .T_ENTRY (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop && !bus.PCSrc_F),
    .i_flush (bus.PCSrc_F),
    .i_data  (w_wr_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_valid (w_valid)
  );

  assign bus.imem_addr_F = r_pc;
  assign bus.out_valid_F = w_valid;
  assign bus.out_pc_F    = w_head.pc;
  assign bus.out_instr_F = w_head.instr;
  assign bus.q_count_F   = w_count;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_flush_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_flush_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (bus.PCSrc_F && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
      if (w_full && !w_pop && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_flush_cnt_F = r_flush_cnt;
  assign perf_stall_cnt_F = r_stall_cnt;
`endif

endmodule
`default_nettype wire
